// File: rtl/header_stream_sequencer_if.sv
// Section beat inputs and the merged set_bit output bus of the header stream sequencer.
// The sequencer uses the master view; the section producers and the bit packer use the slave view.
interface header_stream_sequencer_if #(
  parameter int NUM_SEC = 5,
  parameter int VAL_W   = 64
);
  logic [NUM_SEC-1:0]       sec_valid;
  logic [NUM_SEC*VAL_W-1:0] sec_val;
  logic [NUM_SEC*7-1:0]     sec_size;
  logic [NUM_SEC-1:0]       sec_last;
  logic [NUM_SEC-1:0]       sec_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [VAL_W-1:0]         out_val;
  logic [6:0]               out_size;
  logic                     out_flush;

  modport master (
    input  sec_valid, sec_val, sec_size, sec_last, out_ready,
    output sec_ready, out_valid, out_val, out_size, out_flush
  );

  modport slave (
    output sec_valid, sec_val, sec_size, sec_last, out_ready,
    input  sec_ready, out_valid, out_val, out_size, out_flush
  );
endinterface

// File: rtl/header_stream_sequencer.sv
// Walks enabled header sections in index order, forwards their bit beats onto one
// set_bit bus, pads sections to byte boundaries and records each section's start byte.
module header_stream_sequencer #(
  parameter int                 NUM_SEC    = 5,
  parameter int                 VAL_W      = 64,
  parameter int                 CNT_W      = 32,
  parameter logic [NUM_SEC-1:0] ALIGN_MASK = '1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_SEC-1:0]       sec_en,
  header_stream_sequencer_if.master bus,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         total_bits,
  output logic [NUM_SEC*CNT_W-1:0] sec_offset
);
  localparam int CUR_W = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_XFER, S_PAD, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [CUR_W-1:0]         cur_q, cur_d, sel_idx;
  logic [NUM_SEC-1:0]       en_q, en_d;
  logic [CNT_W-1:0]         total_q, total_d, total_after;
  logic [NUM_SEC*CNT_W-1:0] offset_q, offset_d;
  logic [2:0]               pad_q, pad_d, pad_calc;
  logic [VAL_W-1:0]         cur_val;
  logic [6:0]               cur_size_raw, cur_size;
  logic                     cur_valid, cur_last, cur_align, has_next, pad_needed;

  // Mux the current section's beat and look up the next enabled section.
  always_comb begin
    cur_val      = '0;
    cur_size_raw = 7'd0;
    cur_valid    = 1'b0;
    cur_last     = 1'b0;
    cur_align    = 1'b0;
    sel_idx      = cur_q;
    has_next     = 1'b0;
    for (int i = NUM_SEC - 1; i >= 0; i--) begin
      sel_idx      = (en_q[i] && (CUR_W'(i) >= cur_q)) ? CUR_W'(i) : sel_idx;
      has_next     = has_next | (en_q[i] && (CUR_W'(i) > cur_q));
      cur_val      = (CUR_W'(i) == cur_q) ? bus.sec_val[i*VAL_W +: VAL_W] : cur_val;
      cur_size_raw = (CUR_W'(i) == cur_q) ? bus.sec_size[i*7 +: 7] : cur_size_raw;
      cur_valid    = (CUR_W'(i) == cur_q) ? bus.sec_valid[i] : cur_valid;
      cur_last     = (CUR_W'(i) == cur_q) ? bus.sec_last[i] : cur_last;
      cur_align    = (CUR_W'(i) == cur_q) ? ALIGN_MASK[i] : cur_align;
    end
    // Oversized beats are illegal; clamp rather than corrupt the bit count.
    cur_size    = (cur_size_raw > 7'd64) ? 7'd64 : cur_size_raw;
    total_after = total_q + CNT_W'(cur_size);
    pad_calc    = 3'd0 - total_after[2:0];
    pad_needed  = cur_align && (pad_calc != 3'd0);
  end

  // Pass sequencing: next state, counters and the set_bit bus drive.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    en_d          = en_q;
    total_d       = total_q;
    offset_d      = offset_q;
    pad_d         = pad_q;
    bus.sec_ready = '0;
    bus.out_valid = 1'b0;
    bus.out_val   = '0;
    bus.out_size  = 7'd0;
    bus.out_flush = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          en_d     = sec_en;
          total_d  = '0;
          offset_d = '0;
          cur_d    = '0;
          state_d  = (sec_en == '0) ? S_DONE : S_SEL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEL: begin
        cur_d = sel_idx;
        for (int i = 0; i < NUM_SEC; i++) begin
          offset_d[i*CNT_W +: CNT_W] = (CUR_W'(i) == sel_idx) ? (total_q >> 3)
                                                                : offset_q[i*CNT_W +: CNT_W];
        end
        state_d = S_XFER;
      end
      S_XFER: begin
        bus.out_valid = cur_valid;
        bus.out_val   = cur_val;
        bus.out_size  = cur_size;
        bus.sec_ready = NUM_SEC'(bus.out_ready) << cur_q;
        bus.out_flush = cur_last && !pad_needed && !has_next;
        if (cur_valid && bus.out_ready) begin
          total_d = total_after;
          pad_d   = pad_calc;
          if (!cur_last) begin
            state_d = S_XFER;
          end else if (pad_needed) begin
            state_d = S_PAD;
          end else begin
            cur_d   = cur_q + CUR_W'(1);
            state_d = has_next ? S_SEL : S_DONE;
          end
        end else begin
          state_d = S_XFER;
        end
      end
      S_PAD: begin
        bus.out_valid = 1'b1;
        bus.out_size  = {4'd0, pad_q};
        bus.out_flush = !has_next;
        if (bus.out_ready) begin
          total_d = total_q + CNT_W'(pad_q);
          cur_d   = cur_q + CUR_W'(1);
          state_d = has_next ? S_SEL : S_DONE;
        end else begin
          state_d = S_PAD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      en_q     <= '0;
      total_q  <= '0;
      offset_q <= '0;
      pad_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      en_q     <= en_d;
      total_q  <= total_d;
      offset_q <= offset_d;
      pad_q    <= pad_d;
    end
  end

  assign busy       = (state_q == S_SEL) || (state_q == S_XFER) || (state_q == S_PAD);
  assign done       = (state_q == S_DONE);
  assign total_bits = total_q;
  assign sec_offset = offset_q;
endmodule
